// File: rtl/mul32_booth_seq.sv
// Sequential radix-4 Booth signed multiplier with start/busy/done handshake and HI/LO product words.
// Optional overflow flag output enabled by defining MUL32_OVF_FLAG_EN.
module mul32_booth_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef MUL32_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned PW    = WIDTH + 2;
    localparam int unsigned AW    = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH:0]   m_q, m_nxt;
    logic [AW-1:0]    acc, acc_nxt;
    logic             busy_nxt, done_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    logic [PW-1:0]    a_ext, a_dbl, pp, hi_sum;
    logic [AW-1:0]    acc_step;

`ifdef MUL32_OVF_FLAG_EN
    logic             ovf_nxt;
`endif

    // Booth digit from the three low bits of the shifting multiplier (M[-1] sits at bit 0)
    always_comb begin
        a_ext = {{2{a_q[WIDTH-1]}}, a_q};
        a_dbl = a_ext << 1;
        pp    = '0;
        case (m_q[2:0])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_dbl;
            3'b100:         pp = PW'(0) - a_dbl;
            3'b101, 3'b110: pp = PW'(0) - a_ext;
            default:        pp = '0;
        endcase
        hi_sum   = acc[AW-1:WIDTH] + pp;
        acc_step = {{2{hi_sum[PW-1]}}, hi_sum, acc[WIDTH-1:2]};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        m_nxt     = m_q;
        acc_nxt   = acc;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        hi_nxt    = HI;
        lo_nxt    = LO;
`ifdef MUL32_OVF_FLAG_EN
        ovf_nxt   = ovf;
`endif
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    a_nxt     = A;
                    m_nxt     = {M, 1'b0};
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                acc_nxt = acc_step;
                m_nxt   = {2'b00, m_q[WIDTH:2]};
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(STEPS - 1)) begin
                    hi_nxt    = acc_step[2*WIDTH-1:WIDTH];
                    lo_nxt    = acc_step[WIDTH-1:0];
`ifdef MUL32_OVF_FLAG_EN
                    ovf_nxt   = (acc_step[2*WIDTH-1:WIDTH] != {WIDTH{acc_step[WIDTH-1]}});
`endif
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            m_q   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
`ifdef MUL32_OVF_FLAG_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            a_q   <= a_nxt;
            m_q   <= m_nxt;
            acc   <= acc_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            HI    <= hi_nxt;
            LO    <= lo_nxt;
`ifdef MUL32_OVF_FLAG_EN
            ovf   <= ovf_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mul32_booth_seq.sv
// Directed self-checking bench for mul32_booth_seq (WIDTH=32), with overflow checks when MUL32_OVF_FLAG_EN is defined.
module tb_mul32_booth_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A, M;
    logic        busy, done;
    logic [31:0] HI, LO;
`ifdef MUL32_OVF_FLAG_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    mul32_booth_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .M     (M),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
`ifdef MUL32_OVF_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one op; returns edges from the start-sampling edge until done is seen (sampled on negedge)
    task automatic do_op(input logic [31:0] a, input logic [31:0] m, output int lat);
        @(negedge clk);
        A = a; M = m; start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        A = ~a; M = ~m;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (lat >= 100) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic mul_chk(input string tag, input logic [31:0] a, input logic [31:0] m,
                           input logic [63:0] exp);
        int lat;
        do_op(a, m, lat);
        chk(tag, {HI, LO}, exp);
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [31:0] lo_cap;
        logic [31:0] ra, rm;
        longint      p;

        rst = 1'b1; start = 1'b0; A = '0; M = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", {busy, done, HI, LO}, '0);
        rst = 1'b0;

        // Latency and basic product
        do_op(32'd3, 32'd7, lat);
        chk("lat", 64'(lat), 64'd17);
        chk("3x7", {HI, LO}, 64'h0000_0000_0000_0015);
        chk("busy_done", 64'(busy), 64'd1);
        @(negedge clk);
        chk("done_clr", {busy, done}, 2'b00);

        mul_chk("m5x6", 32'hFFFF_FFFB, 32'd6, 64'hFFFF_FFFF_FFFF_FFE2);
        mul_chk("6xm5", 32'd6, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFE2);
        mul_chk("neg_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        mul_chk("max_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        mul_chk("neg_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        do_op(32'd0, 32'd12345, lat);
        chk("zero_lat", 64'(lat), 64'd17);
        chk("zero", {HI, LO}, 64'd0);
        @(negedge clk);

        // Start while busy is ignored
        @(negedge clk);
        A = 32'd2; M = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_calc", 64'(busy), 64'd1);
        A = 32'd9; M = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; lo_cap = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin pulses++; lo_cap = LO; end
            @(negedge clk);
        end
        chk("one_pulse", 64'(pulses), 64'd1);
        chk("ign_lo", 64'(lo_cap), 64'd4);
        mul_chk("9x9", 32'd9, 32'd9, 64'h0000_0000_0000_0051);

        // Reset mid-CALC aborts the op
        @(negedge clk);
        A = 32'h1234; M = 32'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid", {busy, done, HI, LO}, '0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (done) pulses++;
        end
        chk("no_done_rst", 64'(pulses), 64'd0);
        mul_chk("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

`ifdef MUL32_OVF_FLAG_EN
        mul_chk("ovf_prod", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        chk("ovf_set", 64'(ovf), 64'd1);
        mul_chk("m1_prod", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        chk("ovf_m1", 64'(ovf), 64'd0);
        mul_chk("neg1_prod", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        chk("ovf_neg1", 64'(ovf), 64'd0);
`endif

        // Random sweep against a signed 64-bit multiply
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rm = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            p  = longint'($signed(ra)) * longint'($signed(rm));
            mul_chk("rand", ra, rm, 64'(p));
`ifdef MUL32_OVF_FLAG_EN
            chk("rand_ovf", 64'(ovf), 64'((p > 64'sd2147483647) || (p < -64'sd2147483648)));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
